apa102_frame_tx: RTL and testbench

Parametrised APA102 LED-strand frame transmitter that replaces the free-running shift-and-reload SPI scheme. Each frame is started on request with a start/busy/done handshake and has an exact, known length. LED pixel data is read one LED at a time from an external frame buffer through an index/data port, so strand length no longer sets the width of a parallel input bus. One instance drives one strand; the top level instantiates one per strand (lanterns, rain strands).

---
 rtl/apa102_frame_tx.sv | 161 ++++++++++++++++
 tb/tb_apa102_frame_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apa102_frame_tx.sv
// APA102 strand frame transmitter: start word, NUM_LEDS pixel words read from an
// external synchronous frame buffer, then END_WORDS all-ones words, MSB first.
module apa102_frame_tx #(
    parameter int NUM_LEDS  = 14,
    parameter int HALF_DIV  = 64,
    parameter int END_WORDS = 1,
    parameter int IDX_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             auto_refresh,
    input  logic [4:0]       bright,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] pix_idx,
    input  logic [23:0]      pix_data,
    output logic             sck,
    output logic             mosi
);

    localparam int DIV_W     = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int MAX_WORDS = (NUM_LEDS > END_WORDS) ? NUM_LEDS : END_WORDS;
    localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START_W,
        LED_W,
        END_W
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   divCnt_q, divCnt_d;
    logic               sck_q, sck_d;
    logic [4:0]         bitCnt_q, bitCnt_d;
    logic [CNT_W-1:0]   wordCnt_q, wordCnt_d;
    logic [31:0]        shift_q, shift_d;
    logic [4:0]         bright_q, bright_d;
    logic [IDX_W-1:0]   pixIdx_q, pixIdx_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               accept;
    int                 nextIdx;

    // Word sequencing happens on sck falling edges; the frame buffer index runs one
    // LED ahead of the word being shifted so its data is ready at the next load.
    always_comb begin
        state_d   = state_q;
        divCnt_d  = divCnt_q;
        sck_d     = sck_q;
        bitCnt_d  = bitCnt_q;
        wordCnt_d = wordCnt_q;
        shift_d   = shift_q;
        bright_d  = bright_q;
        pixIdx_d  = pixIdx_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        nextIdx   = 0;

        if (state_q == IDLE) begin
            accept = start;
        end else if (divCnt_q == DIV_W'(HALF_DIV - 1)) begin
            divCnt_d = '0;
            sck_d    = ~sck_q;
            if (sck_q) begin
                if (bitCnt_q != 5'd31) begin
                    bitCnt_d = bitCnt_q + 5'd1;
                    shift_d  = {shift_q[30:0], 1'b0};
                end else begin
                    bitCnt_d = '0;
                    case (state_q)
                        START_W: begin
                            state_d   = LED_W;
                            wordCnt_d = '0;
                            shift_d   = {3'b111, bright_q, pix_data};
                            pixIdx_d  = IDX_W'((NUM_LEDS > 1) ? 1 : 0);
                        end
                        LED_W: begin
                            if (wordCnt_q == CNT_W'(NUM_LEDS - 1)) begin
                                state_d   = END_W;
                                wordCnt_d = '0;
                                shift_d   = '1;
                            end else begin
                                wordCnt_d = wordCnt_q + CNT_W'(1);
                                shift_d   = {3'b111, bright_q, pix_data};
                                nextIdx   = int'(wordCnt_q) + 2;
                                if (nextIdx > NUM_LEDS - 1) begin
                                    nextIdx = NUM_LEDS - 1;
                                end
                                pixIdx_d  = IDX_W'(nextIdx);
                            end
                        end
                        END_W: begin
                            if (wordCnt_q == CNT_W'(END_WORDS - 1)) begin
                                done_d    = 1'b1;
                                state_d   = IDLE;
                                wordCnt_d = '0;
                                shift_d   = '0;
                                pixIdx_d  = '0;
                                accept    = auto_refresh;
                            end else begin
                                wordCnt_d = wordCnt_q + CNT_W'(1);
                                shift_d   = '1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end else begin
            divCnt_d = divCnt_q + DIV_W'(1);
        end

        if (accept) begin
            state_d   = START_W;
            divCnt_d  = '0;
            sck_d     = 1'b0;
            bitCnt_d  = '0;
            wordCnt_d = '0;
            shift_d   = '0;
            bright_d  = bright;
            pixIdx_d  = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            divCnt_q  <= '0;
            sck_q     <= 1'b0;
            bitCnt_q  <= '0;
            wordCnt_q <= '0;
            shift_q   <= '0;
            bright_q  <= '0;
            pixIdx_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            divCnt_q  <= divCnt_d;
            sck_q     <= sck_d;
            bitCnt_q  <= bitCnt_d;
            wordCnt_q <= wordCnt_d;
            shift_q   <= shift_d;
            bright_q  <= bright_d;
            pixIdx_q  <= pixIdx_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sck     = sck_q;
    assign mosi    = shift_q[31];
    assign pix_idx = pixIdx_q;

endmodule

// File: tb/tb_apa102_frame_tx.sv
// Scoreboard bench for apa102_frame_tx: a short strand (A) and a 14-LED strand
// with two end words (B), each fed by a one-cycle-latency frame buffer model.
module tb_apa102_frame_tx;

    localparam int HALF_DIV = 2;
    localparam int LEDS_A   = 2;
    localparam int ENDS_A   = 1;
    localparam int LEDS_B   = 14;
    localparam int ENDS_B   = 2;
    localparam int IDXW_A   = 1;
    localparam int IDXW_B   = 4;
    localparam int FRAME_A  = 2 * HALF_DIV * 32 * (1 + LEDS_A + ENDS_A);
    localparam int FRAME_B  = 2 * HALF_DIV * 32 * (1 + LEDS_B + ENDS_B);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic startA = 1'b0, startB = 1'b0, autoA = 1'b0, autoB = 1'b0;
    logic [4:0] brightA = '0, brightB = '0;
    logic busyA, doneA, sckA, mosiA, busyB, doneB, sckB, mosiB;
    logic [IDXW_A-1:0] pixIdxA;
    logic [IDXW_B-1:0] pixIdxB;
    logic [23:0] pixDataA, pixDataB;
    logic [23:0] ramA [LEDS_A];
    logic [23:0] ramB [LEDS_B];

    logic [31:0] expA[$];
    logic [31:0] expB[$];
    int checks = 0, errors = 0;
    int doneTotA = 0, doneTotB = 0, lastLenA = 0, lastLenB = 0;
    int busyFallB = 0, extraA = 0, extraB = 0;
    int base, fallBase;

    apa102_frame_tx #(.NUM_LEDS(LEDS_A), .HALF_DIV(HALF_DIV), .END_WORDS(ENDS_A)) dutA (
        .clk(clk), .reset(reset), .start(startA), .auto_refresh(autoA), .bright(brightA),
        .busy(busyA), .done(doneA), .pix_idx(pixIdxA), .pix_data(pixDataA),
        .sck(sckA), .mosi(mosiA)
    );

    apa102_frame_tx #(.NUM_LEDS(LEDS_B), .HALF_DIV(HALF_DIV), .END_WORDS(ENDS_B)) dutB (
        .clk(clk), .reset(reset), .start(startB), .auto_refresh(autoB), .bright(brightB),
        .busy(busyB), .done(doneB), .pix_idx(pixIdxB), .pix_data(pixDataB),
        .sck(sckB), .mosi(mosiB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pixDataA <= ramA[pixIdxA];
        pixDataB <= ramB[pixIdxB];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic pushFrame(input bit isB);
        if (!isB) begin
            expA.push_back(32'h0);
            for (int k = 0; k < LEDS_A; k++) expA.push_back({3'b111, brightA, ramA[k]});
            for (int k = 0; k < ENDS_A; k++) expA.push_back(32'hFFFF_FFFF);
        end else begin
            expB.push_back(32'h0);
            for (int k = 0; k < LEDS_B; k++) expB.push_back({3'b111, brightB, ramB[k]});
            for (int k = 0; k < ENDS_B; k++) expB.push_back(32'hFFFF_FFFF);
        end
    endtask

    task automatic applyStimulus(input bit isB);
        @(negedge clk);
        if (isB) startB = 1'b1; else startA = 1'b1;
        pushFrame(isB);
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic compareWord(input bit isB, input logic [31:0] word);
        if (!isB) begin
            if (expA.size() == 0) extraA++;
            else checkOutput("wordA", word, expA.pop_front());
        end else begin
            if (expB.size() == 0) extraB++;
            else checkOutput("wordB", word, expB.pop_front());
        end
    endtask

    task automatic waitIdle(input bit isB, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = isB ? !busyB : !busyA;
        end
        if (!seen) checkOutput("idleTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone(input bit isB, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = isB ? doneB : doneA;
        end
        if (!seen) checkOutput("doneTimeout", 32'd0, 32'd1);
    endtask

    // Reassembles words from mosi on sck rising edges and tracks busy/done/pix_idx.
    task automatic monitor(input bit isB);
        logic prevSck = 1'b0, prevBusy = 1'b0, prevChained = 1'b0;
        logic s, m, b, d;
        logic [31:0] word = '0;
        int nBits = 0, run = 0, cyc = 0, lastDone = 0, prevIdx = 0, maxIdx = 0, idx;
        forever begin
            @(negedge clk);
            cyc++;
            s   = isB ? sckB : sckA;
            m   = isB ? mosiB : mosiA;
            b   = isB ? busyB : busyA;
            d   = isB ? doneB : doneA;
            idx = isB ? int'(pixIdxB) : int'(pixIdxA);
            if (reset) begin
                nBits = 0; prevSck = 1'b0; prevBusy = 1'b0; run = 0;
                prevIdx = 0; maxIdx = 0; prevChained = 1'b0;
            end else begin
                if (s && !prevSck) begin
                    word = {word[30:0], m};
                    nBits++;
                    if (nBits == 32) begin
                        nBits = 0;
                        compareWord(isB, word);
                    end
                end
                prevSck = s;
                if (b) run++;
                if (!b && prevBusy) begin
                    if (isB) begin lastLenB = run; busyFallB++; end
                    else lastLenA = run;
                    run = 0;
                end
                prevBusy = b;
                if (d) begin
                    if (isB) doneTotB++; else doneTotA++;
                    if (isB) begin
                        checkOutput("pixIdxMax", 32'(maxIdx), 32'(LEDS_B - 1));
                        checkOutput("pixIdxAtDone", 32'(idx), 32'd0);
                        if (prevChained) checkOutput("donePeriod", 32'(cyc - lastDone), 32'(FRAME_B));
                        prevChained = b;
                        lastDone = cyc;
                        maxIdx = 0;
                    end
                end
                if (isB && idx != prevIdx) begin
                    if (idx != 0) checkOutput("pixIdxStep", 32'(idx), 32'(prevIdx + 1));
                    if (idx > maxIdx) maxIdx = idx;
                end
                prevIdx = idx;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        fork
            monitor(1'b0);
            monitor(1'b1);
        join_none

        ramA[0] = 24'hFF0000;
        ramA[1] = 24'h00FF00;
        for (int k = 0; k < LEDS_B; k++) ramB[k] = 24'h5A_0000 ^ (24'(k + 1) * 24'h01_0203);

        repeat (3) @(negedge clk);
        checkOutput("resetBusyA", 32'(busyA), 32'd0);
        checkOutput("resetDoneA", 32'(doneA), 32'd0);
        checkOutput("resetSckA", 32'(sckA), 32'd0);
        checkOutput("resetMosiA", 32'(mosiA), 32'd0);
        checkOutput("resetIdxB", 32'(pixIdxB), 32'd0);
        reset = 1'b0;

        $display("[TB] basic frame");
        brightA = 5'h1F;
        base = doneTotA;
        applyStimulus(1'b0);
        waitIdle(1'b0, FRAME_A + 50);
        repeat (10) @(negedge clk);
        checkOutput("basicBusyLen", 32'(lastLenA), 32'(FRAME_A));
        checkOutput("basicDones", 32'(doneTotA - base), 32'd1);
        checkOutput("basicQueue", 32'(expA.size()), 32'd0);

        $display("[TB] start while busy");
        base = doneTotA;
        applyStimulus(1'b0);
        repeat (39) @(negedge clk);
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        waitIdle(1'b0, FRAME_A + 50);
        repeat (FRAME_A + 20) @(negedge clk);
        checkOutput("busyStartLen", 32'(lastLenA), 32'(FRAME_A));
        checkOutput("busyStartDones", 32'(doneTotA - base), 32'd1);
        checkOutput("busyStartIdle", 32'(busyA), 32'd0);

        $display("[TB] reset mid-frame");
        base = doneTotA;
        applyStimulus(1'b0);
        repeat (150) @(negedge clk);
        checkOutput("midBusy", 32'(busyA), 32'd1);
        checkOutput("midIdx", 32'(pixIdxA), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("abortSck", 32'(sckA), 32'd0);
        checkOutput("abortMosi", 32'(mosiA), 32'd0);
        checkOutput("abortBusy", 32'(busyA), 32'd0);
        checkOutput("abortIdx", 32'(pixIdxA), 32'd0);
        expA.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (FRAME_A) @(negedge clk);
        checkOutput("abortDones", 32'(doneTotA - base), 32'd0);
        brightA = 5'h0A;
        ramA[0] = 24'h123456;
        ramA[1] = 24'hABCDEF;
        base = doneTotA;
        applyStimulus(1'b0);
        waitIdle(1'b0, FRAME_A + 50);
        repeat (10) @(negedge clk);
        checkOutput("freshBusyLen", 32'(lastLenA), 32'(FRAME_A));
        checkOutput("freshDones", 32'(doneTotA - base), 32'd1);
        checkOutput("freshQueue", 32'(expA.size()), 32'd0);

        $display("[TB] auto refresh, brightness capture, frame buffer reads");
        brightB = 5'h1F;
        autoB = 1'b1;
        base = doneTotB;
        fallBase = busyFallB;
        applyStimulus(1'b1);
        repeat (300) @(negedge clk);
        brightB = 5'h03;
        for (int f = 0; f < 3; f++) begin
            waitDone(1'b1, FRAME_B + 50);
            pushFrame(1'b1);
            if (f == 2) autoB = 1'b0;
        end
        waitIdle(1'b1, FRAME_B + 50);
        repeat (10) @(negedge clk);
        checkOutput("autoDones", 32'(doneTotB - base), 32'd4);
        checkOutput("autoBusyFalls", 32'(busyFallB - fallBase), 32'd1);
        checkOutput("autoBusyLen", 32'(lastLenB), 32'(4 * FRAME_B));
        checkOutput("autoQueue", 32'(expB.size()), 32'd0);

        checkOutput("extraWordsA", 32'(extraA), 32'd0);
        checkOutput("extraWordsB", 32'(extraB), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
